// File: rtl/alu_share_arbiter.sv
//------------------------------------------------------------------------------
// Module : alu_share_arbiter
// Brief  : Round-robin sharing of one combinational ALU between two requesters,
//          with a one-entry registered response slot per requester.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [2*DATA_W-1:0] req_a_i,
  input  logic [2*DATA_W-1:0] req_b_i,
  input  logic [2*CTRL_W-1:0] req_ctrl_i,
  output logic [1:0]          rsp_valid_o,
  input  logic [1:0]          rsp_ready_i,
  output logic [2*DATA_W-1:0] rsp_result_o,
  output logic [1:0]          rsp_zero_o,
  output logic [1:0]          rsp_err_o,
  output logic [DATA_W-1:0]   alu_a_o,
  output logic [DATA_W-1:0]   alu_b_o,
  output logic [CTRL_W-1:0]   alu_ctrl_o,
  input  logic [DATA_W-1:0]   alu_result_i,
  output logic [CNT_W-1:0]    op_count_o
);

  localparam logic [CTRL_W-1:0] c_ctrl_idle = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] c_ctrl_err  = CTRL_W'(7);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  slot_state_t         r_state [2];
  logic [2*DATA_W-1:0] r_rsp_result;
  logic [1:0]          r_rsp_zero;
  logic [1:0]          r_rsp_err;
  logic [CNT_W-1:0]    r_op_count;
  logic                r_last_grant;

  logic [1:0]          w_rsp_valid;
  logic [1:0]          w_elig;
  logic                w_gnt_any;
  logic                w_gnt_idx;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [CTRL_W-1:0]   w_sel_ctrl;
  logic                w_is_err;
  logic [DATA_W-1:0]   w_capture;

  assign w_rsp_valid[0] = (r_state[0] == S_FULL);
  assign w_rsp_valid[1] = (r_state[1] == S_FULL);

  // A slot can accept a new request in the same cycle it is being drained.
  always_comb begin
    w_elig      = req_valid_i & (~w_rsp_valid | rsp_ready_i);
    w_gnt_any   = !rst_i && (|w_elig);
    w_gnt_idx   = (&w_elig) ? ~r_last_grant : w_elig[1];
    req_ready_o = 2'b00;
    if (w_gnt_any) begin
      req_ready_o[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_sel_a    = w_gnt_idx ? req_a_i[2*DATA_W-1:DATA_W]    : req_a_i[DATA_W-1:0];
    w_sel_b    = w_gnt_idx ? req_b_i[2*DATA_W-1:DATA_W]    : req_b_i[DATA_W-1:0];
    w_sel_ctrl = w_gnt_idx ? req_ctrl_i[2*CTRL_W-1:CTRL_W] : req_ctrl_i[CTRL_W-1:0];
    alu_a_o    = w_gnt_any ? w_sel_a    : '0;
    alu_b_o    = w_gnt_any ? w_sel_b    : '0;
    alu_ctrl_o = w_gnt_any ? w_sel_ctrl : c_ctrl_idle;
    w_is_err   = (alu_ctrl_o == c_ctrl_err);
    w_capture  = w_is_err ? '0 : alu_result_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state[0]   <= S_EMPTY;
      r_state[1]   <= S_EMPTY;
      r_rsp_result <= '0;
      r_rsp_zero   <= '0;
      r_rsp_err    <= '0;
      r_op_count   <= '0;
      r_last_grant <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_gnt_any && (w_gnt_idx == 1'(i))) begin
          r_state[i]                        <= S_FULL;
          r_rsp_result[i*DATA_W +: DATA_W]  <= w_capture;
          r_rsp_zero[i]                     <= (w_capture == '0);
          r_rsp_err[i]                      <= w_is_err;
        end else if (rsp_ready_i[i]) begin
          r_state[i] <= S_EMPTY;
        end
      end
      if (w_gnt_any) begin
        r_op_count   <= r_op_count + CNT_W'(1);
        r_last_grant <= w_gnt_idx;
      end
    end
  end

  assign rsp_valid_o  = w_rsp_valid;
  assign rsp_result_o = r_rsp_result;
  assign rsp_zero_o   = r_rsp_zero;
  assign rsp_err_o    = r_rsp_err;
  assign op_count_o   = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_alu_share_arbiter
// Brief  : Randomized and directed self-checking bench for alu_share_arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_share_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_ctrl;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_result;
  logic [1:0]  rsp_zero;
  logic [1:0]  rsp_err;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [15:0] op_count;

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(3), .CNT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_ctrl_i   (req_ctrl),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero),
    .rsp_err_o    (rsp_err),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_ctrl_o   (alu_ctrl),
    .alu_result_i (alu_result),
    .op_count_o   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU; the unsupported code returns garbage so zeroing is visible.
  function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return a - b;
      3'b100:  return a << b[4:0];
      3'b101:  return a + b;
      3'b110:  return a >> b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b1;

  // Reference model: what each response slot should hold, and whose turn it is.
  bit          m_valid [2];
  logic [31:0] m_result [2];
  bit          m_zero [2];
  bit          m_err [2];
  logic [15:0] m_count;
  int          m_last;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_result[i] = '0; m_zero[i] = 0; m_err[i] = 0;
    end
    m_count = '0;
    m_last  = 1;
  endtask

  task automatic set_req(input int i, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b);
    req_ctrl[i*3 +: 3]  = c;
    req_a[i*32 +: 32]   = a;
    req_b[i*32 +: 32]   = b;
  endtask

  // One clock: check against the model at negedge, advance the model at posedge.
  task automatic tick();
    bit          elig [2];
    int          g;
    logic [1:0]  exp_ready;
    logic [2:0]  gc;
    logic [31:0] ga, gb, res;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      elig[i] = req_valid[i] && (!m_valid[i] || rsp_ready[i]);
    g = -1;
    if (!rst) begin
      if (elig[0] && elig[1]) g = (m_last == 0) ? 1 : 0;
      else if (elig[0])       g = 0;
      else if (elig[1])       g = 1;
    end
    exp_ready = 2'b00;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      gc = req_ctrl[g*3 +: 3];
      ga = req_a[g*32 +: 32];
      gb = req_b[g*32 +: 32];
    end else begin
      gc = 3'b101; ga = '0; gb = '0;
    end
    if (chk_en) begin
      check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
      check_eq("alu_a", 64'(alu_a), 64'(ga));
      check_eq("alu_b", 64'(alu_b), 64'(gb));
      check_eq("alu_ctrl", 64'(alu_ctrl), 64'(gc));
      check_eq("op_count", 64'(op_count), 64'(m_count));
      for (int i = 0; i < 2; i++) begin
        check_eq("rsp_valid", 64'(rsp_valid[i]), 64'(m_valid[i]));
        if (m_valid[i]) begin
          check_eq("rsp_result", 64'(rsp_result[i*32 +: 32]), 64'(m_result[i]));
          check_eq("rsp_zero", 64'(rsp_zero[i]), 64'(m_zero[i]));
          check_eq("rsp_err", 64'(rsp_err[i]), 64'(m_err[i]));
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++)
        if (m_valid[i] && rsp_ready[i]) m_valid[i] = 0;
      if (g >= 0) begin
        res         = (gc == 3'b111) ? 32'h0 : alu_fn(gc, ga, gb);
        m_valid[g]  = 1;
        m_result[g] = res;
        m_zero[g]   = (res == 0);
        m_err[g]    = (gc == 3'b111);
        m_last      = g;
        m_count     = m_count + 16'd1;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_ctrl = '0;
    model_reset();
    @(posedge clk); #1;
    // Reset held with requests present: no grant may be issued.
    req_valid = 2'b11;
    tick();
    rst = 1'b0; req_valid = 2'b00;
    check_eq("reset_valid", 64'(rsp_valid), 64'd0);
    check_eq("reset_result", rsp_result, 64'd0);
    check_eq("reset_zero_err", 64'({rsp_zero, rsp_err}), 64'd0);
    check_eq("reset_count", 64'(op_count), 64'd0);

    // Single ADD from requester 0.
    set_req(0, 3'b101, 32'd5, 32'd7);
    req_valid = 2'b01; rsp_ready = 2'b11;
    tick();
    req_valid = 2'b00;
    check_eq("add_result", 64'(rsp_result[31:0]), 64'd12);
    check_eq("add_count", 64'(op_count), 64'd1);
    tick();

    // Both requesters valid every cycle: strict alternation.
    set_req(1, 3'b000, 32'hF0F0, 32'hFF00);
    req_valid = 2'b11;
    repeat (6) tick();
    req_valid = 2'b00;
    check_eq("alt_count", 64'(op_count), 64'd7);

    // Slot 1 held full, requester 0 keeps winning until slot 1 drains.
    rsp_ready = 2'b01;
    set_req(1, 3'b010, 32'h1234, 32'h00FF);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b11;
    repeat (4) tick();
    rsp_ready = 2'b11;
    tick();
    check_eq("drain_grant_slot1", 64'(rsp_result[63:32]), 64'(32'h1234 ^ 32'h00FF));
    req_valid = 2'b00;
    tick();

    // Zero result and unsupported control.
    set_req(0, 3'b011, 32'd9, 32'd9);
    req_valid = 2'b01;
    tick();
    check_eq("sub_zero", 64'(rsp_zero[0]), 64'd1);
    set_req(0, 3'b111, 32'd3, 32'd4);
    tick();
    check_eq("err_flag", 64'(rsp_err[0]), 64'd1);
    check_eq("err_result", 64'(rsp_result[31:0]), 64'd0);

    // Reset with both slots pending, then the first tie goes to requester 0.
    rsp_ready = 2'b00; req_valid = 2'b11;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_drop_valid", 64'(rsp_valid), 64'd0);
    tick();
    check_eq("rst_tie_first", 64'(rsp_valid), 64'b01);
    rsp_ready = 2'b11; req_valid = 2'b00;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        set_req(i, 3'($urandom_range(0, 7)), a, b);
      end
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      tick();
    end

    // Run the operation counter up to its last value, then wrap it.
    chk_en = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b11;
    set_req(0, 3'b101, 32'd1, 32'd2);
    set_req(1, 3'b101, 32'd3, 32'd4);
    for (int n = 0; n < 70000 && m_count != 16'hFFFF; n++) tick();
    chk_en = 1'b1;
    check_eq("pre_wrap_count", 64'(op_count), 64'hFFFF);
    tick();
    check_eq("wrap_count", 64'(op_count), 64'd0);
    req_valid = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
